// File: rtl/puf_eval_controller_pkg.sv
// Shared definitions for the arbiter-PUF evaluation controller: state codes
// and the sizing helpers used for its counters.
package puf_eval_controller_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_SETUP  = 3'd1;
  localparam logic [ST_W-1:0] ST_PULSE  = 3'd2;
  localparam logic [ST_W-1:0] ST_SETTLE = 3'd3;
  localparam logic [ST_W-1:0] ST_SAMPLE = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE   = 3'd5;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    for (int unsigned b = 1; b < 32; b++) begin
      if ((max_val >> b) != 0) w = b + 1;
    end
    return w;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/puf_eval_controller_resp_sync.sv
// Two-flop synchronizer bringing the asynchronous PUF arbiter output into iclk.
module resp_sync (
  input  logic iclk,
  input  logic irst,
  input  logic iasync,
  output logic osync
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge iclk) begin
    if (irst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= iasync;
      sync_q <= meta_q;
    end
  end

  assign osync = sync_q;

endmodule

// File: rtl/puf_eval_controller.sv
// Steps a PUF through C_NUM_RESP challenges per request, majority-voting
// C_REPEAT evaluations per challenge, and returns the assembled response word.
module puf_eval_controller
  import puf_eval_controller_pkg::*;
#(
  parameter int unsigned C_LENGTH   = 3,
  parameter int unsigned C_NUM_RESP = 8,
  parameter int unsigned C_SETUP    = 2,
  parameter int unsigned C_PULSE_W  = 4,
  parameter int unsigned C_SETTLE   = 4,
  parameter int unsigned C_REPEAT   = 1
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  ivalid,
  input  logic [C_LENGTH-1:0]   ichallenge,
  output logic                  oready,
  output logic [C_LENGTH-1:0]   ochallenge,
  output logic                  opulse,
  input  logic                  iresponse,
  output logic [C_NUM_RESP-1:0] oword,
  output logic                  ovalid,
  input  logic                  iready,
  output logic                  obusy
);

  localparam int unsigned PH_W = cnt_width(max3(C_SETUP, C_PULSE_W, C_SETTLE) - 1);
  localparam int unsigned RP_W = cnt_width(C_REPEAT);
  localparam int unsigned IX_W = cnt_width(C_NUM_RESP - 1);

  localparam logic [PH_W-1:0] LD_SETUP  = PH_W'(C_SETUP - 1);
  localparam logic [PH_W-1:0] LD_PULSE  = PH_W'(C_PULSE_W - 1);
  localparam logic [PH_W-1:0] LD_SETTLE = PH_W'(C_SETTLE - 1);
  localparam logic [RP_W-1:0] REP_MAX   = RP_W'(C_REPEAT);
  localparam logic [RP_W-1:0] VOTE_HALF = RP_W'(C_REPEAT / 2);
  localparam logic [IX_W-1:0] IDX_LAST  = IX_W'(C_NUM_RESP - 1);

  logic [ST_W-1:0]       state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [RP_W-1:0]       rep_q, rep_d, rep_n;
  logic [RP_W-1:0]       vote_q, vote_d, vote_n;
  logic [IX_W-1:0]       idx_q, idx_d;
  logic [C_LENGTH-1:0]   chal_q, chal_d;
  logic [C_NUM_RESP-1:0] word_q, word_d;
  logic                  opulse_q;
  logic                  resp_s;

  resp_sync u_resp_sync (
    .iclk   (iclk),
    .irst   (irst),
    .iasync (iresponse),
    .osync  (resp_s)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rep_d   = rep_q;
    vote_d  = vote_q;
    idx_d   = idx_q;
    chal_d  = chal_q;
    word_d  = word_q;
    rep_n   = rep_q + RP_W'(1);
    vote_n  = vote_q + RP_W'(resp_s);

    case (state_q)
      ST_IDLE: begin
        if (ivalid) begin
          chal_d  = ichallenge;
          word_d  = '0;
          idx_d   = '0;
          vote_d  = '0;
          rep_d   = '0;
          phase_d = LD_SETUP;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_q == '0) begin
          phase_d = LD_PULSE;
          state_d = ST_PULSE;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ST_PULSE: begin
        if (phase_q == '0) begin
          phase_d = LD_SETTLE;
          state_d = ST_SETTLE;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ST_SETTLE: begin
        if (phase_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ST_SAMPLE: begin
        phase_d = LD_SETUP;
        // Re-evaluate the same challenge until C_REPEAT votes are in, then
        // commit the majority bit and advance to the next challenge.
        if (rep_n < REP_MAX) begin
          vote_d  = vote_n;
          rep_d   = rep_n;
          state_d = ST_SETUP;
        end else begin
          word_d[idx_q] = (vote_n > VOTE_HALF);
          vote_d = '0;
          rep_d  = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IX_W'(1);
            chal_d  = chal_q + C_LENGTH'(1);
            state_d = ST_SETUP;
          end
        end
      end
      ST_DONE: begin
        if (iready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      rep_q    <= '0;
      vote_q   <= '0;
      idx_q    <= '0;
      chal_q   <= '0;
      word_q   <= '0;
      opulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      rep_q    <= rep_d;
      vote_q   <= vote_d;
      idx_q    <= idx_d;
      chal_q   <= chal_d;
      word_q   <= word_d;
      opulse_q <= (state_d == ST_PULSE);
    end
  end

  // oready is gated by irst so it is low throughout reset yet high in the
  // very first cycle after reset is released.
  assign oready     = (state_q == ST_IDLE) && !irst;
  assign obusy      = (state_q != ST_IDLE);
  assign ovalid     = (state_q == ST_DONE);
  assign opulse     = opulse_q;
  assign ochallenge = chal_q;
  assign oword      = word_q;

endmodule
